// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch PC, in-order imem request issue and QDEPTH-entry instruction queue
// Optional misaligned-redirect trap marker: define IF_MISALIGN_TRAP_EN.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic            out_misalign
`endif
);
  localparam int PW = $clog2(QDEPTH);
  // Requests issued after a redirect can still be in flight at the next one, so
  // the drop counter gets headroom beyond a single queue's worth.
  localparam int CW = PW + 4;
  localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);

  logic [XLEN-1:0] pc;
  logic [PW:0]     wr_ptr, rd_ptr, fill_ptr;
  logic [CW-1:0]   drop_cnt, drop_total, drop_next;
  logic            running, halted, trap;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_mem    [QDEPTH];
  logic [ILEN-1:0] instr_mem [QDEPTH];

  logic [PW:0]     reserved, outstanding;
  logic [PW-1:0]   wr_idx, rd_idx, fill_idx;
  logic            head_filled, do_req, do_pop, do_fill;

  assign wr_idx   = wr_ptr[PW-1:0];
  assign rd_idx   = rd_ptr[PW-1:0];
  assign fill_idx = fill_ptr[PW-1:0];

  // Slots fill strictly in order, so [rd, fill) is filled and [fill, wr) awaits a response.
  assign reserved    = wr_ptr - rd_ptr;
  assign outstanding = wr_ptr - fill_ptr;
  assign head_filled = fill_ptr != rd_ptr;

  assign imem_req_valid = running && !redirect_valid && !halted && (reserved != QFULL);
  assign imem_req_addr  = pc;
  assign pc_out         = pc;

  assign out_valid = head_filled && !redirect_valid;
  assign out_pc    = head_filled ? pc_mem[rd_idx]    : '0;
  assign out_instr = head_filled ? instr_mem[rd_idx] : '0;

  assign do_req  = imem_req_valid && imem_req_ready;
  assign do_pop  = out_valid && out_ready;
  assign do_fill = imem_rsp_valid && !redirect_valid && (drop_cnt == '0) && (outstanding != '0);

  // A response landing in the redirect cycle belongs to the old stream and is charged here.
  assign drop_total = drop_cnt + CW'(outstanding);
  assign drop_next  = (imem_rsp_valid && drop_total != '0) ? drop_total - CW'(1) : drop_total;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_ptr <= '0;
      drop_cnt <= '0;
      running  <= 1'b0;
    end else begin
      running <= 1'b1;
      if (redirect_valid) begin
        pc       <= redirect_target;
        rd_ptr   <= '0;
        wr_ptr   <= {{PW{1'b0}}, trap};
        fill_ptr <= {{PW{1'b0}}, trap};
        drop_cnt <= drop_next;
      end else begin
        if (do_req) begin
          pc     <= pc + XLEN'(4);
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (do_fill) begin
          fill_ptr <= fill_ptr + 1'b1;
        end else if (imem_rsp_valid && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (redirect_valid && trap) begin
      pc_mem[0]    <= redirect_pc;
      instr_mem[0] <= '0;
    end
    if (do_req) begin
      pc_mem[wr_idx] <= pc;
    end
    if (do_fill) begin
      instr_mem[fill_idx] <= imem_rsp_data;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic [QDEPTH-1:0] mis_mem;

  assign trap            = redirect_pc[1:0] != 2'b00;
  assign redirect_target = redirect_pc;
  assign out_misalign    = head_filled && !redirect_valid && mis_mem[rd_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halted  <= 1'b0;
      mis_mem <= '0;
    end else if (redirect_valid) begin
      halted  <= trap;
      mis_mem <= QDEPTH'(trap);
    end else if (do_req) begin
      mis_mem[wr_idx] <= 1'b0;
    end
  end
`else
  assign trap            = 1'b0;
  assign halted          = 1'b0;
  assign redirect_target = redirect_pc & ~XLEN'(3);
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized scoreboard bench for if_fetch_queue
module tb_if_fetch_queue;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_instr, pc_out;
`ifdef IF_MISALIGN_TRAP_EN
  logic        out_misalign;
`endif

  if_fetch_queue #(.XLEN(32), .ILEN(32), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .pc_out(pc_out)
`ifdef IF_MISALIGN_TRAP_EN
    , .out_misalign(out_misalign)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;

  // Reference: program-order list of reserved PCs, how many have data, and an
  // epoch tag per memory request so anything issued before a redirect is stale.
  logic [31:0] sq[$];
  int          m_fill, epoch, last_due, lat_min, lat_max;
  logic [31:0] m_pc;
  bit          m_running, m_halted, m_trap_head, rsp_gaps;
  logic [31:0] mem_addr[$];
  int          mem_tag[$], mem_due[$];
  int          n_pop;
  logic [31:0] pops_seen[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic model_reset();
    sq.delete(); mem_addr.delete(); mem_tag.delete(); mem_due.delete();
    m_fill = 0; m_pc = RESET_PC; m_running = 0; m_halted = 0; m_trap_head = 0;
    epoch++; last_due = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; redirect_valid = 0; imem_req_ready = 0; imem_rsp_valid = 0; out_ready = 0;
    model_reset();
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy, input bit ordy);
    bit exp_rv, exp_ov, rsp, fire, pop;
    int tag, due;
    logic [31:0] exp_instr;
    tag = -1;
    redirect_valid = rv; redirect_pc = rpc; imem_req_ready = rdy; out_ready = ordy;
    rsp = mem_addr.size() > 0 && mem_due[0] <= cyc && (!rsp_gaps || $urandom_range(3, 0) != 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? word_at(mem_addr[0]) : $urandom;
    #1;
    exp_rv = m_running && !rv && !m_halted && sq.size() < QDEPTH;
    exp_ov = !rv && m_fill > 0;
    checks++;
    if (imem_req_valid !== exp_rv) begin
      failures++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
    end
    checks++;
    if (pc_out !== m_pc || imem_req_addr !== m_pc) begin
      failures++; $display("FAIL fetch_pc cyc=%0d pc_out=%h addr=%h exp=%h", cyc, pc_out, imem_req_addr, m_pc);
    end
    checks++;
    if (out_valid !== exp_ov) begin
      failures++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_ov);
    end
    if (exp_ov) begin
      exp_instr = m_trap_head ? 32'h0 : word_at(sq[0]);
      checks++;
      if (out_pc !== sq[0] || out_instr !== exp_instr) begin
        failures++;
        $display("FAIL head cyc=%0d pc=%h instr=%h exp_pc=%h exp_instr=%h", cyc, out_pc, out_instr, sq[0], exp_instr);
      end
    end
`ifdef IF_MISALIGN_TRAP_EN
    checks++;
    if (out_misalign !== (exp_ov && m_trap_head)) begin
      failures++; $display("FAIL out_misalign cyc=%0d got=%b exp=%b", cyc, out_misalign, exp_ov && m_trap_head);
    end
`endif
    fire = exp_rv && rdy;
    pop  = exp_ov && ordy;
    if (pop) begin n_pop++; pops_seen.push_back(out_pc); end
    if (rsp) begin
      tag = mem_tag.pop_front(); void'(mem_addr.pop_front()); void'(mem_due.pop_front());
    end
    if (rv) begin
      epoch++; sq.delete(); m_fill = 0; m_trap_head = 0; m_halted = 0;
`ifdef IF_MISALIGN_TRAP_EN
      m_pc = rpc;
      if (rpc[1:0] != 2'b00) begin
        sq.push_back(rpc); m_fill = 1; m_trap_head = 1; m_halted = 1;
      end
`else
      m_pc = rpc & ~32'h3;
`endif
    end else begin
      if (rsp && tag == epoch && m_fill < sq.size()) m_fill++;
      if (pop) begin void'(sq.pop_front()); m_fill--; m_trap_head = 0; end
      if (fire) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due < last_due) due = last_due;
        last_due = due;
        sq.push_back(m_pc);
        mem_addr.push_back(m_pc); mem_tag.push_back(epoch); mem_due.push_back(due);
        m_pc = m_pc + 32'd4;
      end
    end
    m_running = 1;
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (pc_out !== RESET_PC || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_values pc=%h ov=%b opc=%h oi=%h rv=%b", pc_out, out_valid, out_pc, out_instr, imem_req_valid);
    end
    @(negedge clk); reset_n = 1'b1;
    lat_min = 1; lat_max = 1; rsp_gaps = 0;
    step(0, 0, 1, 1);
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      failures++; $display("FAIL first_request got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int pops_before;
    apply_reset(); pops_seen.delete();
    lat_min = 1; lat_max = 1; rsp_gaps = 0;
    repeat (5) step(0, 0, 1, 1);
    pops_before = n_pop;
    repeat (20) step(0, 0, 1, 1);
    checks++;
    if (n_pop - pops_before !== 20) begin
      failures++; $display("FAIL stream_throughput got=%0d exp=20", n_pop - pops_before);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pops_seen[i] !== 32'(i * 4)) begin
        failures++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, pops_seen[i], 32'(i * 4));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset(); pops_seen.delete();
    lat_min = 1; lat_max = 2; rsp_gaps = 0;
    repeat (10) step(0, 0, 1, 0);
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || pc_out !== 32'h10) begin
      failures++; $display("FAIL full_stall req_valid=%b pc=%h exp=0/00000010", imem_req_valid, pc_out);
    end
    repeat (12) step(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (pops_seen.size() <= i || pops_seen[i] !== 32'(i * 4)) begin
        failures++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, pops_seen.size() > i ? pops_seen[i] : 32'hX, 32'(i * 4));
      end
    end
  endtask

  task automatic test_redirect();
    int guard;
    apply_reset(); pops_seen.delete();
    lat_min = 3; lat_max = 3; rsp_gaps = 0;
    guard = 0;
    while (mem_addr.size() != 3 && guard < 30) begin step(0, 0, 1, 1); guard++; end
    checks++;
    if (guard >= 30) begin failures++; $display("FAIL redirect_setup got=%0d outstanding exp=3", mem_addr.size()); end
    pops_seen.delete();
    step(1, 32'h100, 1, 1);
    repeat (12) step(0, 0, 1, 1);
    checks++;
    if (pops_seen.size() == 0 || pops_seen[0] !== 32'h100) begin
      failures++; $display("FAIL redirect_first got=%h exp=00000100", pops_seen.size() ? pops_seen[0] : 32'hX);
    end
`ifndef IF_MISALIGN_TRAP_EN
    step(1, 32'h102, 0, 0);
    #1;
    checks++;
    if (pc_out !== 32'h100) begin failures++; $display("FAIL redirect_align got=%h exp=00000100", pc_out); end
`endif
  endtask

  task automatic test_wrap();
    apply_reset(); pops_seen.delete();
    lat_min = 1; lat_max = 1; rsp_gaps = 0;
    step(0, 0, 0, 0);
    step(1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 1, 0);
    #1;
    checks++;
    if (pc_out !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%h exp=00000000", pc_out); end
    repeat (6) step(0, 0, 1, 1);
    checks++;
    if (pops_seen.size() < 2 || pops_seen[0] !== 32'hFFFF_FFFC || pops_seen[1] !== 32'h0) begin
      failures++; $display("FAIL wrap_order got=%h,%h exp=fffffffc,00000000",
                           pops_seen.size() > 0 ? pops_seen[0] : 32'hX, pops_seen.size() > 1 ? pops_seen[1] : 32'hX);
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    apply_reset();
    lat_min = 1; lat_max = 4; rsp_gaps = 1;
    for (int i = 0; i < 400; i++) begin
      rpc = $urandom;
      if ($urandom_range(3, 0) != 0) rpc[1:0] = 2'b00;
      step($urandom_range(24, 0) == 0, rpc, $urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    lat_min = 1; lat_max = 3; rsp_gaps = 0;
    repeat (6) step(0, 0, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (pc_out !== RESET_PC || out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset pc=%h ov=%b rv=%b", pc_out, out_valid, imem_req_valid);
    end
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    repeat (15) step(0, 0, 1, 1);
  endtask

`ifdef IF_MISALIGN_TRAP_EN
  task automatic test_misalign();
    apply_reset(); pops_seen.delete();
    lat_min = 1; lat_max = 1; rsp_gaps = 0;
    repeat (4) step(0, 0, 1, 1);
    step(1, 32'h102, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    repeat (4) step(0, 0, 1, 1);
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL halted_req got=%b exp=0", imem_req_valid); end
    pops_seen.delete();
    step(1, 32'h200, 1, 1);
    repeat (6) step(0, 0, 1, 1);
    checks++;
    if (pops_seen.size() == 0 || pops_seen[0] !== 32'h200) begin
      failures++; $display("FAIL trap_resume got=%h exp=00000200", pops_seen.size() ? pops_seen[0] : 32'hX);
    end
  endtask
`endif

  initial begin
    epoch = 0; n_pop = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
`ifdef IF_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch front end. Owns the fetch PC, issues in-order requests to instruction memory with a valid/ready handshake, and buffers returned instructions with their PCs in a QDEPTH-entry queue. Supports back-pressure from decode and flush/redirect from execute. Sits between the PC-select logic and the IF/ID pipeline register.

## Interface
- XLEN, 32: PC/address width.
- ILEN, 32: instruction width.
- QDEPTH, 4: queue entries; power of two, ≥2. Also bounds outstanding requests.
- RESET_PC, 32'h0000_0000: fetch PC after reset.
---
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  flush queue and load redirect_pc.
- redirect_pc  in  XLEN  new fetch PC.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  XLEN  fetch address, equal to pc_out.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response; exactly one per accepted request, in order, ≥1 cycle after acceptance.
- imem_rsp_data  in  ILEN  instruction word.
- out_valid  out  1  queue head valid.
- out_pc  out  XLEN  PC of head.
- out_instr  out  ILEN  instruction of head.
- out_ready  in  1  decode consumes head.
- pc_out  out  XLEN  current fetch PC.
- out_misalign  out  1  head is a misalignment marker (present only with IF_MISALIGN_TRAP_EN).

## Operation
- Queue: QDEPTH slots, circular, wr/rd pointers with wrap bit. A slot is reserved at request acceptance, storing the PC; it is filled with imem_rsp_data on response. out_valid = head reserved AND filled AND !redirect_valid.
- Credit: imem_req_valid = (reserved slots < QDEPTH) && !redirect_valid && !halted. On imem_req_valid && imem_req_ready: reserve slot, pc <= pc + 4 (mod 2^XLEN, wraps silently).
- Pop: out_valid && out_ready frees the head.
- Redirect (highest priority): all slots freed, pointers reset to 0, pc <= redirect_pc, halted cleared. Requests outstanding at that edge load into drop_cnt; the next drop_cnt responses are discarded, decrementing drop_cnt. A response arriving in the redirect cycle itself counts toward drop_cnt. Pop and request are suppressed in the redirect cycle.
- Simultaneous push (response), pop, and reserve in one cycle: all take effect; occupancy = reserved − popped.
- Response with no outstanding, non-dropped request: protocol violation; ignored.

## Timing
- Reset values: pc_out = RESET_PC, out_valid = 0, out_pc = 0, out_instr = 0, imem_req_valid = 0, out_misalign = 0, drop_cnt = 0, queue empty.
- First request is issued the cycle after reset_n deasserts, with imem_req_addr = RESET_PC.
- Latency: request accepted at edge N, response at edge N+k (k≥1), out_valid high from cycle N+k+1.
- Streaming throughput is 1 instruction/cycle when the memory responds every cycle and out_ready = 1.
- Full: QDEPTH reserved, imem_req_valid = 0 until a pop. Empty: out_valid = 0.
- reset_n asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. Responses arriving after reset for pre-reset requests are the memory's responsibility; this block ignores them via the rule for responses with no outstanding request.

## Configuration
- IF_MISALIGN_TRAP_EN defined: a redirect_pc with [1:0] != 0 issues no request. It reserves and fills one slot with out_pc = redirect_pc, out_instr = 0, out_misalign = 1, then sets halted. Halted clears only on the next redirect.
- IF_MISALIGN_TRAP_EN undefined: the out_misalign port is absent, and redirect_pc[1:0] is forced to 2'b00 on load.

## Test plan
- Reset then stream with imem_req_ready = 1, 1-cycle response, and out_ready = 1: out_pc sequence is 0x0, 0x4, 0x8, …, one per cycle from cycle 2.
- Hold out_ready = 0 with QDEPTH = 4: after exactly 4 accepted requests, imem_req_valid = 0 and pc_out = 0x10. Release: the 4 entries drain in order and requests resume.
- Redirect to 0x100 with 3 requests outstanding: the next 3 responses are dropped, and the first out_pc after the redirect is 0x100.
- Response, pop, and request in the same cycle at occupancy 2: occupancy stays 2 and no entry is lost or duplicated.
- pc = 0xFFFF_FFFC with a request accepted: pc_out wraps to 0x0.
- With IF_MISALIGN_TRAP_EN, redirect to 0x102: one entry appears with out_misalign = 1 and out_pc = 0x102, no imem request is issued until the next redirect, and a redirect to 0x200 resumes fetch.
